// File: rtl/row_chk_pkg.sv
// Shared types and default parameter values for the row checksum checker.
package row_chk_pkg;

    typedef enum logic [1:0] {
        ST_ACC,
        ST_DRAIN,
        ST_CMP
    } state_e;

    localparam int A_BITS_DEF = 18;
    localparam int Z_BITS_DEF = 20;
    localparam int N_DEF      = 4;
    localparam int TOL_DEF    = 0;
    localparam int CNT_W_DEF  = 8;

endpackage

// File: rtl/sat_cnt.sv
// Saturating event counter with a synchronous clear that beats increment.
module sat_cnt
    import row_chk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/row_chk.sv
// Streams N-element rows into an external accumulator and checks the sum.
// Define ROW_CHK_TOL_EN to accept sums within +/-TOL of the checksum.
module row_chk
    import row_chk_pkg::*;
#(
    parameter int aBits = A_BITS_DEF,
    parameter int zBits = Z_BITS_DEF,
    parameter int N     = N_DEF,
    parameter int TOL   = TOL_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [aBits-1:0] s_data,
    output logic [aBits-1:0] acc_a,
    output logic             acc_clear,
    input  logic [zBits-1:0] acc_z,
    input  logic             chk_valid,
    output logic             chk_ready,
    input  logic [zBits-1:0] chk_data,
    output logic             res_valid,
    output logic             res_err,
    output logic [CNT_W-1:0] err_cnt,
    input  logic             err_clr
);

    localparam int CW  = $clog2(N);
    localparam int ZW1 = zBits + 1;

`ifdef ROW_CHK_TOL_EN
    localparam bit TOL_EN = 1'b1;
`else
    localparam bit TOL_EN = 1'b0;
`endif

    // A zero threshold makes "magnitude > THR" the same as "not equal".
    localparam logic [zBits:0] THR = TOL_EN ? ZW1'(TOL) : '0;

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic            res_valid_q;
    logic            res_err_q;

    logic            beat;
    logic            last;
    logic            cmp_hs;
    logic            mismatch;
    logic [zBits:0]  diff;
    logic [zBits:0]  mag;

    assign s_ready   = (state_q == ST_ACC);
    assign chk_ready = (state_q == ST_CMP);
    assign beat      = s_valid && s_ready;
    assign last      = (cnt_q == CW'(N - 1));
    assign cmp_hs    = chk_ready && chk_valid;

    assign acc_a     = (beat && !rst) ? s_data : '0;
    assign acc_clear = s_ready && (cnt_q == '0);

    assign diff = {acc_z[zBits-1], acc_z}
                - {chk_data[zBits-1], chk_data};
    assign mag  = diff[zBits] ? -diff : diff;
    assign mismatch = (mag > THR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ACC;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            unique case (state_q)
                ST_ACC: begin
                    if (beat) begin
                        if (last) begin
                            cnt_q   <= '0;
                            state_q <= ST_DRAIN;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                // accumulator output settles with the last element here
                ST_DRAIN: begin
                    state_q <= ST_CMP;
                end
                ST_CMP: begin
                    if (chk_valid) begin
                        res_valid_q <= 1'b1;
                        res_err_q   <= mismatch;
                        state_q     <= ST_ACC;
                    end
                end
                default: begin
                    state_q <= ST_ACC;
                end
            endcase
        end
    end

    assign res_valid = res_valid_q;
    assign res_err   = res_err_q;

    sat_cnt #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (cmp_hs && mismatch),
        .clr   (err_clr),
        .cnt_o (err_cnt)
    );

endmodule

// File: tb/tb_row_chk.sv
// Directed bench for row_chk with a bench-side accumulator and row-sum model.
module tb_row_chk;

    localparam int AB   = 18;
    localparam int ZB   = 20;
    localparam int NE   = 4;
    localparam int TOLV = 1;
    localparam int CW   = 2;
    localparam int CMAX = 3;

`ifdef ROW_CHK_TOL_EN
    localparam bit TOL_EN = 1'b1;
`else
    localparam bit TOL_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AB-1:0] s_data = '0;
    logic [AB-1:0] acc_a;
    logic          acc_clear;
    logic [ZB-1:0] acc_z;
    logic          chk_valid = 1'b0;
    logic          chk_ready;
    logic [ZB-1:0] chk_data = '0;
    logic          res_valid;
    logic          res_err;
    logic [CW-1:0] err_cnt;
    logic          err_clr = 1'b0;

    int n_chk = 0;
    int n_err = 0;
    int n_res = 0;

    always #5 clk = ~clk;

    row_chk #(
        .aBits (AB),
        .zBits (ZB),
        .N     (NE),
        .TOL   (TOLV),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .acc_a     (acc_a),
        .acc_clear (acc_clear),
        .acc_z     (acc_z),
        .chk_valid (chk_valid),
        .chk_ready (chk_ready),
        .chk_data  (chk_data),
        .res_valid (res_valid),
        .res_err   (res_err),
        .err_cnt   (err_cnt),
        .err_clr   (err_clr)
    );

    // downstream accumulator: registered, sign-extending, load on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_z <= '0;
        else if (acc_clear) acc_z <= {{(ZB-AB){acc_a[AB-1]}}, acc_a};
        else acc_z <= acc_z + {{(ZB-AB){acc_a[AB-1]}}, acc_a};
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic bit row_mismatch(input int sum,
                                        input logic [ZB-1:0] c);
        logic signed [ZB-1:0] s;
        int d;
        s = sum[ZB-1:0];
        d = int'(s) - int'($signed(c));
        if (d < 0) d = -d;
        return TOL_EN ? (d > TOLV) : (d != 0);
    endfunction

    // model: 0 = collecting, 1 = one settle cycle, 2 = awaiting checksum
    int m_phase = 0;
    int m_n     = 0;
    int m_sum   = 0;
    bit m_rv    = 0;
    bit m_re    = 0;
    int m_cnt   = 0;

    always @(posedge clk or posedge rst) begin
        bit mis;
        if (rst) begin
            m_phase = 0; m_n = 0; m_sum = 0;
            m_rv = 0; m_re = 0; m_cnt = 0;
        end else begin
            m_rv = 0;
            case (m_phase)
                0: if (s_valid) begin
                    m_sum += $signed(s_data);
                    m_n++;
                    if (m_n == NE) m_phase = 1;
                end
                1: m_phase = 2;
                default: if (chk_valid) begin
                    mis = row_mismatch(m_sum, chk_data);
                    m_rv = 1;
                    m_re = mis;
                    if (mis && m_cnt < CMAX) m_cnt++;
                    m_phase = 0; m_n = 0; m_sum = 0;
                end
            endcase
            if (err_clr) m_cnt = 0;
        end
    end

    always @(negedge clk) begin
        chk("s_ready", 32'(s_ready), 32'(m_phase == 0));
        chk("chk_ready", 32'(chk_ready), 32'(m_phase == 2));
        chk("acc_clear", 32'(acc_clear),
            32'(m_phase == 0 && m_n == 0));
        chk("res_valid", 32'(res_valid), 32'(m_rv));
        if (m_rv) chk("res_err", 32'(res_err), 32'(m_re));
        chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
        if (res_valid) n_res++;
    end

    task automatic run_row(input string nm,
                           input logic [AB-1:0] e0, e1, e2, e3,
                           input logic [ZB-1:0] c,
                           input bit early, input bit gaps,
                           input bit clr,
                           input bit ed, input int cd,
                           input bit et, input int ct);
        logic [AB-1:0] el[4];
        int drains;
        bit done;
        el = '{e0, e1, e2, e3};
        if (early) begin
            chk_valid = 1'b1;
            chk_data  = c;
        end
        for (int i = 0; i < NE; i++) begin
            if (gaps) begin
                s_valid = 1'b0;
                repeat (i + 1) begin @(posedge clk); #1; end
            end
            s_valid = 1'b1;
            s_data  = el[i];
            @(posedge clk); #1;
        end
        s_valid   = 1'b0;
        s_data    = '0;
        chk_valid = 1'b1;
        chk_data  = c;
        drains = 0;
        done   = 0;
        for (int k = 0; k < 8 && !done; k++) begin
            if (chk_ready) begin
                err_clr = clr;
                @(posedge clk); #1;
                err_clr = 1'b0;
                done = 1;
            end else begin
                if (!s_ready) drains++;
                @(posedge clk); #1;
            end
        end
        chk_valid = 1'b0;
        chk({nm, "_handshake"}, 32'(done), 32'd1);
        chk({nm, "_drain"}, 32'(drains), 32'd1);
        chk({nm, "_res_valid"}, 32'(res_valid), 32'd1);
        chk({nm, "_res_err"}, 32'(res_err), 32'(TOL_EN ? et : ed));
        chk({nm, "_err_cnt"}, 32'(err_cnt), 32'(TOL_EN ? ct : cd));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        s_valid = 1'b1;
        s_data  = 18'h155;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_chk_ready", 32'(chk_ready), 32'd0);
        chk("rst_acc_clear", 32'(acc_clear), 32'd1);
        chk("rst_acc_a", 32'(acc_a), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        s_valid = 1'b0;
        s_data  = '0;
        rst     = 1'b0;

        run_row("r1_sum10", 1, 2, 3, 4, 10, 0, 0, 0, 0, 0, 0, 0);
        run_row("r2_sum10_c11", 1, 2, 3, 4, 11, 0, 0, 0, 1, 1, 0, 0);
        run_row("r3_neg", 18'h3FFFF, 18'h3FFFF, 18'h3FFFF,
                18'h3FFFF, 20'hFFFFC, 0, 0, 0, 0, 1, 0, 0);
        run_row("r4_early_gaps", 5, 6, 7, 8, 26, 1, 1, 0,
                0, 1, 0, 0);

        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_pulse", 32'(err_cnt), 32'd0);

        run_row("sat1", 1, 2, 3, 4, 0, 0, 0, 0, 1, 1, 1, 1);
        run_row("sat2", 1, 2, 3, 4, 0, 0, 0, 0, 1, 2, 1, 2);
        run_row("sat3", 1, 2, 3, 4, 0, 0, 0, 0, 1, 3, 1, 3);
        run_row("sat4", 1, 2, 3, 4, 0, 0, 0, 0, 1, 3, 1, 3);
        run_row("sat5", 1, 2, 3, 4, 0, 0, 0, 0, 1, 3, 1, 3);
        run_row("clr_wins", 1, 2, 3, 4, 0, 0, 0, 1, 1, 0, 1, 0);
        run_row("tol", 1, 2, 3, 4, 11, 0, 0, 0, 1, 1, 0, 0);

        s_valid = 1'b1;
        s_data  = 18'd7;
        @(posedge clk); #1;
        s_data  = 18'd9;
        @(posedge clk); #1;
        s_valid = 1'b0;
        s_data  = '0;
        rst     = 1'b1;
        @(posedge clk); #1;
        chk("midrst_err_cnt", 32'(err_cnt), 32'd0);
        chk("midrst_acc_clear", 32'(acc_clear), 32'd1);
        rst = 1'b0;

        run_row("after_rst", 5, 5, 5, 5, 20, 0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("result_pulses", 32'(n_res), 32'd12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
